// File: rtl/adc_dac_pkg.sv
// adc_dac_pkg
// Shared constants and types for the ADC decimation datapath:
//   IN_W / OUT_W      : input sample and requantized output widths
//   SAT_MAX / SAT_MIN : signed limits for the requantized output
//   dec_state_e       : decimator FSM state encoding
package adc_dac_pkg;

  localparam int IN_W  = 24;
  localparam int OUT_W = 8;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } dec_state_e;

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
// Synchronous FIFO holding requantized output samples.
// A push is taken when the FIFO is not full, or when it is full and a pop
// happens in the same cycle (the popped slot is rewritten). The storage is
// reset so that the head reads 0 while in reset.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   push, push_data: write request and data
//   pop            : read request (ignored when empty)
//   full, empty    : occupancy status
//   head           : oldest entry, read straight from the storage registers
module adc_sample_fifo
  import adc_dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [OUT_W-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [OUT_W-1:0] head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_data_decimation.sv
// adc_data_decimation
// Averages DECIM signed 24-bit ADC samples, requantizes the sum to a signed
// 8-bit sample (arithmetic shift by log2(DECIM)+16, then saturation) and
// queues the result in an output FIFO.
// Build option: define ADC_DECIM_ROUND_EN to round half up before the shift;
// otherwise the shift truncates toward negative infinity.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   enn                 : block enable; low freezes accumulation, FIFO drains
//   in_valid, in_data   : ADC sample input, in_ready accepts it
//   out_valid, out_data : FIFO head, popped when out_ready is high
//   sat_flag            : sticky, set when any emitted sample was clipped
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for the first sample of a group
// ST_ACCUM | summing samples, cnt_q = samples still needed
// ST_EMIT  | pushing the requantized sum, waits here while FIFO full
module adc_data_decimation
  import adc_dac_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enn,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             sat_flag
);

  localparam int SH    = $clog2(DECIM);
  localparam int ACC_W = IN_W + SH;
  localparam int RS    = SH + 16;
  // One guard bit so the rounding offset can never overflow the sum.
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = SH;

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(SAT_MIN);

  dec_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] shv;
  logic                    clip_hi;
  logic                    clip_lo;
  logic [OUT_W-1:0]        result;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Reset gates in_ready directly so nothing is offered as accepted while
  // rst_n is held low.
  assign in_ready = rst_n & enn & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
  assign accept   = in_valid & in_ready;
  assign in_ext   = {{SH{in_data[IN_W-1]}}, in_data};

`ifdef ADC_DECIM_ROUND_EN
  localparam logic signed [SUM_W-1:0] RND =
    {{(SUM_W-RS){1'b0}}, 1'b1, {(RS-1){1'b0}}};
  assign sum_r = $signed({acc_q[ACC_W-1], acc_q}) + RND;
`else
  assign sum_r = $signed({acc_q[ACC_W-1], acc_q});
`endif

  assign shv     = sum_r >>> RS;
  assign clip_hi = (shv > SAT_HI);
  assign clip_lo = (shv < SAT_LO);
  assign result  = clip_hi ? OUT_W'(SAT_MAX) :
                   clip_lo ? OUT_W'(SAT_MIN) : shv[OUT_W-1:0];

  assign pop       = out_valid & out_ready;
  assign out_valid = ~fifo_empty;
  assign sat_flag  = sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (push && (clip_hi || clip_lo)) begin
        sat_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = in_ext;
          cnt_d   = CNT_W'(DECIM - 1);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_q + in_ext;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        // A pop in the same cycle frees the slot even when the FIFO is full.
        if (enn && (!fifo_full || pop)) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  adc_sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (result),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

endmodule

// File: tb/tb_adc_data_decimation.sv
module tb_adc_data_decimation;

  localparam int DECIM      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int SHIFT      = $clog2(DECIM) + 16;
`ifdef ADC_DECIM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enn = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  bit done   = 1'b0;
  bit sat_exp = 1'b0;

  logic [23:0] grp_q[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  adc_data_decimation #(.DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enn       (enn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: mean of the group in fixed point, floor-divided, clamped.
  function automatic logic [7:0] ref_out(input longint sum);
    longint v;
    logic [7:0] r;
    v = sum;
    if (ROUND) v = v + (longint'(1) << (SHIFT - 1));
    v = v >>> SHIFT;
    if (v > 127) begin
      v = 127;
      sat_exp = 1'b1;
    end else if (v < -128) begin
      v = -128;
      sat_exp = 1'b1;
    end
    r = v[7:0];
    return r;
  endfunction

  // Monitor: model intake on accepted samples, scoreboard on pops.
  initial begin
    longint s;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        grp_q.delete();
        exp_q.delete();
        sat_exp = 1'b0;
      end else begin
        if (in_valid && in_ready && enn) begin
          grp_q.push_back(in_data);
          if (grp_q.size() == DECIM) begin
            s = 0;
            foreach (grp_q[k]) s += longint'($signed(grp_q[k]));
            exp_q.push_back(ref_out(s));
            grp_q.delete();
          end
        end
        if (out_valid && out_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", longint'($signed(out_data)), longint'($signed(e)));
          end
        end
      end
    end
  end

  task automatic send(input logic [23:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_group(input logic [23:0] d);
    for (int i = 0; i < DECIM; i++) send(d);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("sat_flag", sat_flag, sat_exp);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sat_flag", sat_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] rand_sample();
    logic [23:0] d;
    case ($urandom_range(0, 3))
      0: d = 24'($urandom());
      1: d = 24'h7FFF00 | 24'($urandom_range(0, 255));
      2: d = 24'h800000 | 24'($urandom_range(0, 255));
      default: d = 24'($urandom_range(0, 24'h03FFFF)) - 24'h020000;
    endcase
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    do_reset();
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Basic average and latency: push one cycle after the last sample,
    // visible the cycle after that.
    out_ready = 1'b1;
    send_group(24'h010000);
    chk("lat_t1_out_valid", out_valid, 0);
    chk("emit_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("lat_t2_out_valid", out_valid, 1);
    chk("lat_t2_out_data", out_data, 8'h01);
    drain();

    // Rounding boundary (half LSB).
    send_group(24'h008000);
    drain();

    // Extremes: positive clips only when rounding is enabled.
    send_group(24'h7FFFFF);
    drain();
    send_group(24'h800000);
    drain();

    // Back-pressure: 4 results fill the FIFO, the 5th waits in EMIT.
    out_ready = 1'b0;
    p0 = pops;
    for (int g = 0; g < 5; g++) send_group(24'((g + 1) * 24'h010000));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_after_pop_in_ready", in_ready, 1);
    chk("bp_after_pop_out_valid", out_valid, 1);
    chk("bp_pops_single", pops - p0, 1);
    drain();
    chk("bp_pops_total", pops - p0, 5);

    // Enable dropped mid-group for 5 cycles.
    send(24'h123456);
    send(24'h0F0000);
    enn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("enn_low_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    enn = 1'b1;
    send(24'h2A0000);
    send(24'hFF0000);
    drain();

    // Reset mid-group discards the partial sum.
    send(24'h7FFFFF);
    send(24'h7FFFFF);
    do_reset();
    p0 = pops;
    send_group(24'h020000);
    drain();
    chk("rst_mid_pops", pops - p0, 1);

    // Randomized traffic with random back-pressure and enable.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(rand_sample());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
          enn       = ($urandom_range(0, 7) != 0);
        end
      end
    join
    enn = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_data_decimation.md
ADC_DATA_DECIMATION -- requirements
Module: adc_data_decimation

Interface
REQ-001 Parameter DECIM, default 4: input samples averaged per output sample; power of two, 2..16.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port enn, input, 1: block enable; low freezes sample acceptance.
REQ-006 Port in_valid, input, 1: in_data holds a valid ADC sample.
REQ-007 Port in_data, input, 24: signed two's-complement ADC sample.
REQ-008 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-009 Port out_valid, output, 1: out_data holds a valid sample.
REQ-010 Port out_data, output, 8: signed requantized sample.
REQ-011 Port out_ready, input, 1: consumer accepts out_data this cycle.
REQ-012 Port sat_flag, output, 1: sticky flag, set when any output sample was clipped.

Function
REQ-013 A sample is accepted in a cycle where in_valid, in_ready and enn are all high.
REQ-014 The FSM has three states: IDLE, ACCUM and EMIT.
REQ-015 IDLE goes to ACCUM on the first accepted sample; that sample loads the accumulator.
REQ-016 ACCUM adds each accepted sample to the accumulator and counts samples.
REQ-017 ACCUM goes to EMIT in the cycle after the DECIM-th accepted sample.
REQ-018 The accumulator is signed, 24+log2(DECIM) bits wide, and cannot overflow.
REQ-019 In EMIT the result is the accumulator arithmetically shifted right by log2(DECIM)+16 bits.
REQ-020 The shifted result saturates to the range -128..127, and sat_flag sets on any clip.
REQ-021 EMIT pushes the result into the FIFO and returns to IDLE in the same cycle.
REQ-022 If the FIFO is full in EMIT, the push waits in EMIT; a same-cycle pop frees the entry and allows the push.
REQ-023 in_ready is high only when enn is high and the state is IDLE or ACCUM.
REQ-024 Latency: DECIM-th sample accepted at cycle t, push at t+1, out_valid high at t+2 when the FIFO was empty.
REQ-025 out_valid equals FIFO not empty; out_data is the FIFO head, driven from a register.
REQ-026 A pop occurs when out_valid and out_ready are both high.
REQ-027 The FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 Push and pop in the same cycle leave the occupancy unchanged.
REQ-029 enn low holds the accumulator, sample count and state; the FIFO keeps draining.

Reset
REQ-030 Asserting rst_n low immediately clears the FSM to IDLE, the accumulator and count to 0, and both FIFO pointers.
REQ-031 During reset, out_valid=0, out_data=0, in_ready=0 and sat_flag=0.
REQ-032 Reset mid-accumulation discards the partial sum; no output is produced from it.
REQ-033 sat_flag clears only on reset.

Configuration
REQ-034 With macro ADC_DECIM_ROUND_EN defined, 2^(log2(DECIM)+15) is added before the shift (round half up), then the result saturates.
REQ-035 Without ADC_DECIM_ROUND_EN, the shift truncates toward negative infinity.

Structure
REQ-036 Package adc_dac_pkg holds:
- the sample width constants IN_W=24 and OUT_W=8;
- the FSM state enum;
- the saturation limits.
REQ-037 Sub-module adc_sample_fifo implements the synchronous FIFO (parameter FIFO_DEPTH, data width OUT_W), instantiated once.

Verification (DECIM=4, FIFO_DEPTH=4)
REQ-038 Four samples of 24'h010000, out_ready=1 -> out_data=8'h01 at t+2; sat_flag stays 0.
REQ-039 Four samples of 24'h7FFFFF -> out_data=8'h7F and sat_flag=1 (with ADC_DECIM_ROUND_EN); four samples of 24'h800000 -> out_data=8'h80.
REQ-040 Four samples of 24'h008000 -> out_data=8'h01 with ADC_DECIM_ROUND_EN, 8'h00 without it.
REQ-041 out_ready=0 with 20 samples streamed ->
- four outputs are queued;
- the fifth result holds in EMIT and in_ready=0;
- one pop then pushes it in the same cycle.
REQ-042 rst_n pulsed low after 2 of 4 samples, then four samples of 24'h020000 -> exactly one output, 8'h02.
REQ-043 enn low for 5 cycles in mid-group -> in_ready=0 throughout, and the output value matches the uninterrupted run.
